// File: rtl/instruction_loader.sv
// instruction_loader: serial boot loader in front of the instruction memory
// write port. Frames a UART byte stream as SYNC_BYTE, 16-bit little-endian
// word count, then count*4 instruction bytes. Every four bytes are assembled
// into one 32-bit word and written at consecutive word-aligned addresses.
//
// Handshake: byte_valid is a single-cycle strobe qualifying byte_data in the
// same cycle. There is no ready/back-pressure; the loader accepts a byte in
// every cycle it is offered, in every state, including back-to-back strobes.
// write_enable is a one-cycle strobe; byte_address/write_data are valid in
// that cycle and hold until the next write.
module instruction_loader #(
  parameter int         MEM_BYTES      = 1024,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        write_enable,
  output logic [31:0] byte_address,
  output logic [31:0] write_data,
  output logic        loading,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEN_LO = 2'd1,
    LEN_HI = 2'd2,
    DATA   = 2'd3
  } state_t;

  // Timer wide enough to hold TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_WORDS  = 17'(MEM_BYTES / 4);

  state_t         state;
  logic [7:0]     count_lo;
  logic [15:0]    word_count;
  logic [15:0]    word_idx;
  logic [1:0]     lane;
  logic [23:0]    asm_q;     // lanes 0..2; lane 3 comes straight from byte_data
  logic [TW-1:0]  timer;

  logic [15:0]    len_w;
  logic           last_word;

  // Full length as it becomes known in LEN_HI, and final-word detect in DATA.
  assign len_w     = {byte_data, count_lo};
  assign last_word = (word_idx == (word_count - 16'd1));

  // Frame FSM with registered memory-write, status and timeout logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count_lo     <= '0;
      word_count   <= '0;
      word_idx     <= '0;
      lane         <= '0;
      asm_q        <= '0;
      timer        <= '0;
      write_enable <= 1'b0;
      byte_address <= '0;
      write_data   <= '0;
      loading      <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      if (state == IDLE) begin
        if (byte_valid && (byte_data == SYNC_BYTE)) begin
          state    <= LEN_LO;
          loading  <= 1'b1;
          error    <= 1'b0;
          word_idx <= '0;
          lane     <= '0;
          timer    <= '0;
        end
      end else if (byte_valid) begin
        // Any byte inside a frame restarts the inactivity timer; a SYNC_BYTE
        // here is plain payload, never a restart.
        timer <= '0;
        case (state)
          LEN_LO: begin
            count_lo <= byte_data;
            state    <= LEN_HI;
          end
          LEN_HI: begin
            word_count <= len_w;
            if (len_w == 16'd0) begin
              done    <= 1'b1;
              state   <= IDLE;
              loading <= 1'b0;
            end else if ({1'b0, len_w} > MAX_WORDS) begin
              error   <= 1'b1;
              state   <= IDLE;
              loading <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            case (lane)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                write_data   <= {byte_data, asm_q};
                byte_address <= {14'b0, word_idx, 2'b00};
                write_enable <= 1'b1;
                word_idx     <= word_idx + 16'd1;
                if (last_word) begin
                  done    <= 1'b1;
                  state   <= IDLE;
                  loading <= 1'b0;
                end
              end
            endcase
            lane <= lane + 2'd1;
          end
          default: ;
        endcase
      end else if (timer == TIMER_LAST) begin
        // Stalled frame: abandon it, partial word is simply dropped.
        error   <= 1'b1;
        state   <= IDLE;
        loading <= 1'b0;
        timer   <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule
